// File: rtl/clk_div_cfg_req.sv
// Configuration-port initiator for the integer clock divider: turns register writes into
// valid/ready requests with a one-entry shadow buffer, completion/drop pulses and a sticky timeout.
module clk_div_cfg_req #(
    parameter int unsigned                 DIV_VALUE_WIDTH   = 4,
    parameter logic [DIV_VALUE_WIDTH-1:0]  DEFAULT_DIV_VALUE = '0,
    parameter int unsigned                 TIMEOUT_CYCLES    = 64,
    parameter int unsigned                 CNT_WIDTH         = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  logic [DIV_VALUE_WIDTH-1:0] wr_div_i,
    output logic [DIV_VALUE_WIDTH-1:0] div_o,
    output logic                       div_valid_o,
    input  logic                       div_ready_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       drop_o,
    output logic                       timeout_o,
    input  logic                       timeout_clr_i,
    output logic [DIV_VALUE_WIDTH-1:0] cur_div_o,
    output logic [CNT_WIDTH-1:0]       change_cnt_o
);

    typedef enum logic {
        IDLE,
        REQ
    } state_e;

    localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_e                     state_q, state_d;
    logic [DIV_VALUE_WIDTH-1:0] shadow_q, shadow_d;
    logic                       shadow_full_q, shadow_full_d;
    logic [DIV_VALUE_WIDTH-1:0] div_d;
    logic [TW-1:0]              tmo_cnt_q, tmo_cnt_d;
    logic                       hs;
    logic                       drop_d;
    logic                       tmo_set;

    always_comb begin
        hs            = (state_q == REQ) & div_ready_i;
        state_d       = state_q;
        div_d         = div_o;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        drop_d        = 1'b0;
        tmo_cnt_d     = tmo_cnt_q;
        tmo_set       = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_en_i) begin
                    state_d = REQ;
                    div_d   = wr_div_i;
                end
            end
            REQ: begin
                if (hs) begin
                    tmo_cnt_d = '0;
                    // A full shadow is issued next; a coincident write refills it without a drop.
                    if (shadow_full_q) begin
                        div_d         = shadow_q;
                        shadow_full_d = wr_en_i;
                        if (wr_en_i) begin
                            shadow_d = wr_div_i;
                        end
                    end else if (wr_en_i) begin
                        div_d = wr_div_i;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (wr_en_i) begin
                        shadow_d      = wr_div_i;
                        shadow_full_d = 1'b1;
                        drop_d        = shadow_full_q;
                    end
                    if (TIMEOUT_CYCLES != 0 && tmo_cnt_q != TMO_MAX) begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                        tmo_set   = (tmo_cnt_q == TMO_LAST);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            tmo_cnt_q     <= '0;
            div_o         <= DEFAULT_DIV_VALUE;
            div_valid_o   <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            drop_o        <= 1'b0;
            timeout_o     <= 1'b0;
            cur_div_o     <= DEFAULT_DIV_VALUE;
            change_cnt_o  <= '0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            tmo_cnt_q     <= tmo_cnt_d;
            div_o         <= div_d;
            div_valid_o   <= (state_d == REQ);
            busy_o        <= (state_d == REQ) | shadow_full_d;
            done_o        <= hs;
            drop_o        <= drop_d;
            // Set has priority over a coincident clear.
            timeout_o     <= tmo_set | (timeout_o & ~timeout_clr_i);
            if (hs) begin
                cur_div_o    <= div_o;
                change_cnt_o <= change_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: doc/clk_div_cfg_req.md
Name: clk_div_cfg_req

Overview:
- Handshake initiator that drives the div_i / div_valid_i / div_ready_o configuration port of the integer clock divider.
- Accepts divider-change writes from a simple register-side write strobe and issues them as protocol-compliant requests.
  - Valid and data held stable until accepted.
  - Valid never combinationally dependent on ready.
- Buffers one write that arrives while a request is outstanding.
- Reports completion, overflow and timeout status to software.

Parameters:
- DIV_VALUE_WIDTH, 4, width of divider value; must match the divider instance.
- DEFAULT_DIV_VALUE, 0, value the divider holds after reset; reset value of div_o and cur_div_o.
- TIMEOUT_CYCLES, 64, request-outstanding cycles before timeout_o sets; 0 disables the timeout.
- CNT_WIDTH, 8, width of the completed-change counter.

Ports:
- clk_i  in  1  clock, same domain as the divider's clk_i.
- rst_i  in  1  reset, asynchronous, active-high.
- wr_en_i  in  1  single-cycle write strobe for a new divider value.
- wr_div_i  in  DIV_VALUE_WIDTH  value written with wr_en_i.
- div_o  out  DIV_VALUE_WIDTH  request data; connects to divider div_i.
- div_valid_o  out  1  request valid; connects to divider div_valid_i.
- div_ready_i  in  1  accept; connects from divider div_ready_o.
- busy_o  out  1  request outstanding or shadow occupied.
- done_o  out  1  one-cycle pulse per accepted request.
- drop_o  out  1  one-cycle pulse when a buffered write is overwritten.
- timeout_o  out  1  sticky; request outstanding for at least TIMEOUT_CYCLES.
- timeout_clr_i  in  1  clears timeout_o.
- cur_div_o  out  DIV_VALUE_WIDTH  last value accepted by the divider.
- change_cnt_o  out  CNT_WIDTH  number of accepted requests; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset values:
  - div_o = cur_div_o = DEFAULT_DIV_VALUE.
  - div_valid_o = 0, busy_o = 0, done_o = 0, drop_o = 0, timeout_o = 0, change_cnt_o = 0.
  - Shadow empty, state IDLE, timeout counter = 0.
  - Reset mid-request drops the request and the shadow immediately.
- All outputs are registered; div_valid_o and div_o have no combinational path from any input.
- Two-state FSM, IDLE and REQ.
- IDLE:
  - div_valid_o = 0.
  - wr_en_i at edge N -> REQ; div_o = wr_div_i and div_valid_o = 1 from cycle N+1 (latency 1).
- REQ:
  - div_valid_o = 1 and div_o are held constant until handshake.
  - Handshake = div_valid_o & div_ready_i sampled at an edge. At that edge:
    - cur_div_o <= div_o; change_cnt_o += 1 (wraps); done_o = 1 for the following cycle only.
    - Timeout counter cleared.
    - Shadow full -> stay REQ, div_o <= shadow, shadow emptied; div_valid_o stays 1 with no idle cycle (back-to-back).
    - Shadow empty -> IDLE, div_valid_o <= 0.
  - wr_en_i in REQ without handshake: value goes to shadow.
    - If shadow already full, it is overwritten (last write wins) and drop_o pulses for one cycle.
  - wr_en_i coincident with handshake:
    - Shadow empty: the written value is the next request (issued back-to-back).
    - Shadow full: shadow is issued; the new write replaces it in the shadow... no: the full shadow is issued, the new write goes into the shadow, and there is no drop.
- Timeout:
  - Counter increments each REQ cycle without handshake and saturates at TIMEOUT_CYCLES.
  - Reaching TIMEOUT_CYCLES sets timeout_o; it stays set until timeout_clr_i.
  - Set and clear in the same cycle: set wins.
  - Timeout never deasserts div_valid_o (protocol forbids withdrawing valid).
  - TIMEOUT_CYCLES = 0: timeout_o constant 0.
- busy_o = (state == REQ) | shadow_full, registered.
- Ready while in IDLE is ignored.
- No value filtering: equal or 0/1 values are issued as-is; the divider grants equal values immediately.

Test Plan:
- Reset with DEFAULT_DIV_VALUE=3 -> div_o=3, cur_div_o=3, div_valid_o=0, change_cnt_o=0, busy_o=0.
- wr_div_i=6 strobed at cycle 0; div_ready_i raised at cycle 4 ->
  - div_valid_o=1 and div_o=6 during cycles 1-4.
  - done_o=1 in cycle 5; cur_div_o=6; change_cnt_o=1; div_valid_o=0 from cycle 5.
- Write 5, then writes 7 and 9 while request 5 is outstanding, then ready held high ->
  - drop_o pulses once (when 9 overwrites 7).
  - Requests 5 then 9 issued back-to-back with div_valid_o continuously high.
  - change_cnt_o=2, cur_div_o=9.
- TIMEOUT_CYCLES=64, ready held low for 100 cycles ->
  - timeout_o rises after 64 outstanding cycles; div_valid_o stays 1.
  - timeout_clr_i clears timeout_o; if issued at the same edge as a re-set, timeout_o remains 1.
- wr_en_i with wr_div_i=2 coincident with the handshake of request 4, shadow empty ->
  - done_o pulse; next cycle div_o=2 with div_valid_o still 1.
- rst_i asserted mid-request with shadow full ->
  - Asynchronously div_valid_o=0, busy_o=0, div_o=DEFAULT_DIV_VALUE.
  - After release, no stale request is issued.
